// File: rtl/seg_display_arbiter.sv
// Arbitrates the two-digit 7-segment display between error, compute and background sources.
// Strict priority with error pre-emption, a minimum on-screen hold, and a one-cycle registered decision.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [13:0] pat0,
  input  logic [13:0] pat1,
  input  logic [13:0] pat2,
  output logic [2:0]  gnt,
  output logic [1:0]  owner,
  output logic [13:0] seg_pattern,
  output logic        hold_active,
  output logic        switch_pulse
);

  typedef enum logic [1:0] {ST_BG, ST_HOLD, ST_LINGER} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic [1:0]        owner_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [13:0]       pat_nxt;
  logic [2:0]        gnt_nxt;
  logic              expired, own_req, rearb, go_bg;

  assign expired = (cnt == CNT_MAX);
  assign cnt_inc = expired ? cnt : cnt + 1'b1;
  // Only meaningful in HOLD/LINGER, where owner is always 0 or 1.
  assign own_req = owner[0] ? req[1] : req[0];

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt_inc;
    rearb     = 1'b0;
    go_bg     = 1'b0;
    if (req[0] && owner != 2'd0) begin
      state_nxt = ST_HOLD;
      owner_nxt = 2'd0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_BG: begin
          if (req[1]) begin
            state_nxt = ST_HOLD;
            owner_nxt = 2'd1;
            cnt_nxt   = '0;
          end else begin
            go_bg = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!own_req) begin
            if (expired) rearb = 1'b1;
            else         state_nxt = ST_LINGER;
          end
        end
        ST_LINGER: begin
          if (own_req)      state_nxt = ST_HOLD;
          else if (expired) rearb = 1'b1;
        end
        default: go_bg = 1'b1;
      endcase
      if (rearb) begin
        if (req[1] && owner != 2'd1) begin
          state_nxt = ST_HOLD;
          owner_nxt = 2'd1;
          cnt_nxt   = '0;
        end else begin
          go_bg = 1'b1;
        end
      end
      if (go_bg) begin
        state_nxt = ST_BG;
        owner_nxt = req[2] ? 2'd2 : 2'd3;
        cnt_nxt   = '0;
      end
    end

    // LINGER keeps the registered pattern, which is the frozen snapshot.
    case (state_nxt)
      ST_HOLD:   pat_nxt = (owner_nxt == 2'd0) ? pat0 : pat1;
      ST_LINGER: pat_nxt = seg_pattern;
      default:   pat_nxt = req[2] ? pat2 : 14'h0000;
    endcase

    gnt_nxt = (owner_nxt == 2'd3) ? 3'b000 : (3'b001 << owner_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_BG;
      owner        <= 2'd3;
      gnt          <= 3'b000;
      seg_pattern  <= 14'h0000;
      cnt          <= '0;
      hold_active  <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      gnt          <= gnt_nxt;
      seg_pattern  <= pat_nxt;
      cnt          <= cnt_nxt;
      hold_active  <= (state_nxt != ST_BG) && (cnt_nxt != CNT_MAX);
      switch_pulse <= (owner_nxt != owner);
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed-vector bench for seg_display_arbiter with HOLD_CYCLES=8.
module tb_seg_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [13:0] pat0, pat1, pat2;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic [13:0] seg_pattern;
  logic        hold_active;
  logic        switch_pulse;

  int nvec = 0;
  int nerr = 0;

  seg_display_arbiter #(.HOLD_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .pat0(pat0), .pat1(pat1), .pat2(pat2),
    .gnt(gnt), .owner(owner), .seg_pattern(seg_pattern),
    .hold_active(hold_active), .switch_pulse(switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; pat0 = 14'h3FFF; pat1 = 14'h3FFF; pat2 = 14'h3FFF;
    tick();
    nvec++; if (owner !== 2'd3) begin nerr++; $display("FAIL reset_owner got %0d want 3", owner); end
    nvec++; if (gnt !== 3'b000) begin nerr++; $display("FAIL reset_gnt got %b want 000", gnt); end
    nvec++; if (seg_pattern !== 14'h0) begin nerr++; $display("FAIL reset_seg got %h want 0000", seg_pattern); end
    nvec++; if (hold_active !== 1'b0 || switch_pulse !== 1'b0) begin
      nerr++; $display("FAIL reset_flags got hold=%b sw=%b want 0 0", hold_active, switch_pulse);
    end
    rst_n = 1'b1; req = 3'b000;
  endtask

  task automatic test_background();
    apply_reset();
    req = 3'b100; pat2 = 14'h0C3F;
    tick();
    nvec++; if (owner !== 2'd2 || gnt !== 3'b100) begin
      nerr++; $display("FAIL bg_grant got owner=%0d gnt=%b want 2 100", owner, gnt);
    end
    nvec++; if (seg_pattern !== 14'h0C3F) begin nerr++; $display("FAIL bg_seg got %h want 0c3f", seg_pattern); end
    nvec++; if (switch_pulse !== 1'b1) begin nerr++; $display("FAIL bg_pulse got %b want 1", switch_pulse); end
    nvec++; if (hold_active !== 1'b0) begin nerr++; $display("FAIL bg_hold got %b want 0", hold_active); end
    tick();
    nvec++; if (switch_pulse !== 1'b0 || owner !== 2'd2) begin
      nerr++; $display("FAIL bg_pulse_once got sw=%b owner=%0d want 0 2", switch_pulse, owner);
    end
    req = 3'b000;
    tick();
    nvec++; if (owner !== 2'd3 || gnt !== 3'b000 || seg_pattern !== 14'h0 || switch_pulse !== 1'b1) begin
      nerr++; $display("FAIL bg_blank got owner=%0d gnt=%b seg=%h sw=%b want 3 000 0000 1",
                       owner, gnt, seg_pattern, switch_pulse);
    end
  endtask

  task automatic test_hold_linger();
    apply_reset();
    req = 3'b110; pat1 = 14'h1E77; pat2 = 14'h0C3F;
    tick();
    nvec++; if (owner !== 2'd1 || gnt !== 3'b010 || seg_pattern !== 14'h1E77 || hold_active !== 1'b1) begin
      nerr++; $display("FAIL hl_grant got owner=%0d gnt=%b seg=%h hold=%b want 1 010 1e77 1",
                       owner, gnt, seg_pattern, hold_active);
    end
    tick();
    req = 3'b100; pat1 = 14'h0000;
    for (int k = 2; k <= 7; k++) begin
      tick();
      nvec++;
      if (owner !== 2'd1 || gnt !== 3'b010 || seg_pattern !== 14'h1E77 || hold_active !== (k != 7)) begin
        nerr++; $display("FAIL hl_linger cyc=%0d got owner=%0d gnt=%b seg=%h hold=%b want 1 010 1e77 %b",
                         k, owner, gnt, seg_pattern, hold_active, (k != 7));
      end
    end
    tick();
    nvec++; if (owner !== 2'd2 || seg_pattern !== 14'h0C3F || switch_pulse !== 1'b1 || hold_active !== 1'b0) begin
      nerr++; $display("FAIL hl_release got owner=%0d seg=%h sw=%b hold=%b want 2 0c3f 1 0",
                       owner, seg_pattern, switch_pulse, hold_active);
    end
  endtask

  task automatic test_preempt();
    apply_reset();
    req = 3'b110; pat1 = 14'h1E77; pat2 = 14'h0C3F;
    repeat (4) tick();
    req = 3'b111; pat0 = 14'h3F79;
    tick();
    nvec++; if (owner !== 2'd0 || gnt !== 3'b001 || seg_pattern !== 14'h3F79 || switch_pulse !== 1'b1) begin
      nerr++; $display("FAIL pre_grant got owner=%0d gnt=%b seg=%h sw=%b want 0 001 3f79 1",
                       owner, gnt, seg_pattern, switch_pulse);
    end
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) req = 3'b110;
      tick();
      nvec++;
      if (owner !== 2'd0 || seg_pattern !== 14'h3F79 || hold_active !== (k != 7)) begin
        nerr++; $display("FAIL pre_hold cyc=%0d got owner=%0d seg=%h hold=%b want 0 3f79 %b",
                         k, owner, seg_pattern, hold_active, (k != 7));
      end
    end
    tick();
    nvec++; if (owner !== 2'd1 || gnt !== 3'b010 || seg_pattern !== 14'h1E77 || hold_active !== 1'b1) begin
      nerr++; $display("FAIL pre_resume got owner=%0d gnt=%b seg=%h hold=%b want 1 010 1e77 1",
                       owner, gnt, seg_pattern, hold_active);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req = 3'b011; pat0 = 14'h3F79; pat1 = 14'h1E77;
    for (int k = 0; k < 10; k++) begin
      tick();
      nvec++;
      if (owner !== 2'd0 || gnt !== 3'b001) begin
        nerr++; $display("FAIL sim_owner0 cyc=%0d got owner=%0d gnt=%b want 0 001", k, owner, gnt);
      end
    end
    req = 3'b010;
    tick();
    nvec++; if (owner !== 2'd1 || seg_pattern !== 14'h1E77 || switch_pulse !== 1'b1) begin
      nerr++; $display("FAIL sim_handoff got owner=%0d seg=%h sw=%b want 1 1e77 1",
                       owner, seg_pattern, switch_pulse);
    end
  endtask

  task automatic test_linger_reassert();
    apply_reset();
    req = 3'b010; pat1 = 14'h1E77;
    tick();
    req = 3'b000;
    repeat (4) tick();
    nvec++; if (owner !== 2'd1 || seg_pattern !== 14'h1E77 || hold_active !== 1'b1) begin
      nerr++; $display("FAIL lr_linger got owner=%0d seg=%h hold=%b want 1 1e77 1", owner, seg_pattern, hold_active);
    end
    req = 3'b010; pat1 = 14'h0155;
    tick();
    nvec++; if (owner !== 2'd1 || seg_pattern !== 14'h0155 || hold_active !== 1'b1 || switch_pulse !== 1'b0) begin
      nerr++; $display("FAIL lr_live got owner=%0d seg=%h hold=%b sw=%b want 1 0155 1 0",
                       owner, seg_pattern, hold_active, switch_pulse);
    end
    tick();
    nvec++; if (hold_active !== 1'b1) begin nerr++; $display("FAIL lr_cnt6 got hold=%b want 1", hold_active); end
    tick();
    nvec++; if (hold_active !== 1'b0) begin nerr++; $display("FAIL lr_cnt7 got hold=%b want 0", hold_active); end
    tick();
    nvec++; if (owner !== 2'd1 || hold_active !== 1'b0) begin
      nerr++; $display("FAIL lr_indef got owner=%0d hold=%b want 1 0", owner, hold_active);
    end
  endtask

  task automatic test_reset_in_linger();
    apply_reset();
    req = 3'b010; pat1 = 14'h1E77;
    tick();
    req = 3'b000;
    tick();
    rst_n = 1'b0;
    tick();
    nvec++; if (owner !== 2'd3 || gnt !== 3'b000 || seg_pattern !== 14'h0 || hold_active !== 1'b0 || switch_pulse !== 1'b0) begin
      nerr++; $display("FAIL rl_reset got owner=%0d gnt=%b seg=%h hold=%b sw=%b want 3 000 0000 0 0",
                       owner, gnt, seg_pattern, hold_active, switch_pulse);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      nvec++;
      if (owner !== 2'd3 || gnt !== 3'b000 || seg_pattern !== 14'h0 || switch_pulse !== 1'b0) begin
        nerr++; $display("FAIL rl_blank cyc=%0d got owner=%0d gnt=%b seg=%h sw=%b want 3 000 0000 0",
                         k, owner, gnt, seg_pattern, switch_pulse);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 3'b000; pat0 = '0; pat1 = '0; pat2 = '0;
    test_reset();
    test_background();
    test_hold_linger();
    test_preempt();
    test_simultaneous();
    test_linger_reassert();
    test_reset_in_linger();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the two-digit 7-segment display between three content sources: error reporter, compute-result/status, and the mode/menu background.
It registers a winning 14-bit segment pattern and a one-hot grant each cycle. It enforces strict priority with error pre-emption and a minimum on-screen hold time so that short-lived messages stay readable.
Sits between the requesting FSMs and the 7-segment digit scan driver. The scan driver consumes seg_pattern unchanged.

Parameters:
HOLD_CYCLES, 50000000, minimum cycles a granted requester 0/1 owns the display (0.5 s at 100 MHz); legal range >= 2.
CNT_W, 26, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
req  in  3  level requests: [0]=error (highest), [1]=compute, [2]=background (lowest)
pat0  in  14  requester 0 pattern: [13:7]=left digit, [6:0]=right digit, GFEDCBA, 1=segment lit
pat1  in  14  requester 1 pattern, same format
pat2  in  14  requester 2 pattern, same format
gnt  out  3  registered one-hot grant; 000 when blank
owner  out  2  registered owner id: 0/1/2 = requester, 3 = blank
seg_pattern  out  14  registered pattern to scan driver
hold_active  out  1  1 while hold counter has not expired in HOLD or LINGER
switch_pulse  out  1  one-cycle pulse in the cycle owner takes a new value

Behaviour:
- Reset (rst_n=0 at clk edge): state=BG, owner=3, gnt=000, seg_pattern=0, counter=0, hold_active=0, switch_pulse=0.
- States:
  - BG: background or blank.
  - HOLD: owner 0/1 with its req high.
  - LINGER: owner 0/1 dropped req before the hold expired; a frozen snapshot is displayed.
- Counter: cleared to 0 on every grant to requester 0/1. Increments in HOLD and LINGER and saturates at HOLD_CYCLES-1. expired = (counter == HOLD_CYCLES-1). hold_active = (state != BG) && !expired.
- Next state is decided from inputs sampled at edge N. All outputs reflect the decision at edge N+1, giving one cycle of request-to-grant latency.
- Priority rules, evaluated in this order:
  1. Pre-emption: req[0]=1 and owner!=0 → HOLD, owner 0, counter 0. This applies from any state and ignores the hold of owner 1. A pre-empted requester 1 keeps its request pending; no grant is remembered.
  2. BG: req[1]=1 → HOLD, owner 1, counter 0. Otherwise stay in BG with owner=2 if req[2], else owner=3 and pattern 0.
  3. HOLD, owner o, req[o] still 1 → stay. There is no time limit, so the owner holds indefinitely. While owner 0 holds, requester 1 waits regardless of expiry.
  4. HOLD, req[o] falls, expired → re-arbitrate in the same decision: req[1] and o!=1 → HOLD owner 1; otherwise go to BG.
  5. HOLD, req[o] falls, not expired → LINGER. The snapshot equals the seg_pattern currently displayed.
  6. LINGER, req[o] reasserts → HOLD with the same owner. The counter is not cleared and the live pattern resumes.
  7. LINGER, expired → re-arbitrate as in rule 4, using only the requests present.
- seg_pattern sources:
  - HOLD: live pat0/pat1 of the owner, registered.
  - LINGER: the snapshot.
  - BG: pat2 when req[2]=1, otherwise 0.
- gnt: one-hot of owner in HOLD/LINGER and in BG with req[2]; 000 when owner=3. In LINGER, gnt remains asserted to the lingering owner.
- switch_pulse: 1 in the cycle owner differs from its previous value. A BG change between 2 and 3 counts.
- Simultaneous requests: if req[0] and req[1] rise together, owner 0 wins and requester 1 follows after req[0] drops and its hold is satisfied.
- Reset asserted mid-HOLD/LINGER: the snapshot is discarded and all outputs return to their reset values at that edge.

Test Plan:
HOLD_CYCLES=8 for all scenarios.
- Reset, then req=100, pat2=14'h0C3F → one edge later: owner=2, gnt=100, seg_pattern=14'h0C3F, switch_pulse=1 for one cycle.
- From BG, req[1] high for 2 cycles then low; pat1=14'h1E77 → owner=1 for 8 cycles total (LINGER shows 14'h1E77 after the drop), then owner=2; hold_active is low on the final owner-1 cycle.
- Owner 1 holding, counter=3, raise req[0] with pat0=14'h3F79 → next edge owner=0, gnt=001, seg_pattern=14'h3F79, counter=0; requester 1 is still requested and regains the display after req[0] drops and 8 cycles elapse.
- req[0] and req[1] rise in the same cycle → owner=0; after req[0] has been high for 10 cycles and then drops, owner=1 at the next edge.
- Owner 1 in LINGER at counter=4, req[1] reasserts → HOLD with the live pattern, counter continues from 5 rather than restarting.
- rst_n=0 for one edge during LINGER → owner=3, gnt=000, seg_pattern=0, hold_active=0; with req=000, blank persists.
